// File: rtl/count_modn_chain_pkg.sv
// Shared types and helpers for the cascaded modulo-N counter chain.
// Optional stop-at-terminal behaviour is enabled with COUNT_MODN_STOP_EN.
package count_modn_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    function automatic int unsigned digit_width(input int unsigned modulus);
        return (modulus < 2) ? 1 : $clog2(modulus);
    endfunction

    function automatic int unsigned clamp_digit(input int unsigned value, input int unsigned modulus);
        return (value >= modulus) ? modulus - 1 : value;
    endfunction

endpackage

// File: rtl/count_modn_chain_if.sv
// Control/data bundle between a driver and count_modn_chain.
// The done signal exists only when COUNT_MODN_STOP_EN is defined.
interface count_modn_chain_if
    import count_modn_pkg::*;
#(
    parameter int unsigned MODULUS = 10,
    parameter int unsigned DIGITS  = 2
);
    localparam int unsigned W = digit_width(MODULUS);

    logic                  en;
    logic                  up_dn;
    logic                  clr;
    logic                  load;
    logic [DIGITS*W-1:0]   load_val;
    logic [DIGITS*W-1:0]   count;
    logic                  co;
`ifdef COUNT_MODN_STOP_EN
    logic                  done;

    modport master (output en, up_dn, clr, load, load_val, input count, co, done);
    modport slave  (input en, up_dn, clr, load, load_val, output count, co, done);
`else
    modport master (output en, up_dn, clr, load, load_val, input count, co);
    modport slave  (input en, up_dn, clr, load, load_val, output count, co);
`endif

endinterface

// File: rtl/count_modn_chain_digit.sv
// One modulo-MODULUS digit: clear > load (clamped) > step, wrapping by
// explicit compare so power-of-two moduli behave the same as others.
module count_modn_digit
    import count_modn_pkg::*;
#(
    parameter  int unsigned MODULUS = 10,
    localparam int unsigned W       = digit_width(MODULUS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_d,
    input  logic         step,
    input  logic         up_dn,
    output logic [W-1:0] q,
    output logic         is_term
);
    localparam logic [W-1:0] MAXV = W'(MODULUS - 1);

    logic         up;
    logic [W-1:0] q_next;
    logic [W-1:0] load_c;

    always_comb begin
        up      = (dir_e'(up_dn) == DIR_UP);
        load_c  = W'(clamp_digit(32'(load_d), MODULUS));
        is_term = up ? (q == MAXV) : (q == '0);
        q_next  = q;
        if (up) begin
            q_next = (q == MAXV) ? '0 : q + 1'b1;
        end else begin
            q_next = (q == '0) ? MAXV : q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_c;
        end else if (step) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/count_modn_chain.sv
// DIGITS cascaded modulo-MODULUS digits with ripple carry/borrow and co output.
// Define COUNT_MODN_STOP_EN to hold at terminal (done=1) instead of wrapping.
module count_modn_chain
    import count_modn_pkg::*;
#(
    parameter int unsigned MODULUS = 10,
    parameter int unsigned DIGITS  = 2
) (
    input logic              clk,
    input logic              rst,
    count_modn_chain_if.slave bus
);
    localparam int unsigned W = digit_width(MODULUS);

    logic [DIGITS-1:0] is_term;
    logic [DIGITS-1:0] step;
    logic [W-1:0]      q [DIGITS];
    logic              stall;
    logic              wrap;
    logic              freeze;
    logic              acc;

`ifdef COUNT_MODN_STOP_EN
    logic done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else if (bus.clr || bus.load) begin
            done_q <= 1'b0;
        end else if (wrap) begin
            done_q <= 1'b1;
        end
    end

    assign stall    = done_q;
    assign bus.done = done_q;
`else
    assign stall = 1'b0;
`endif

    // Full wrap is only possible when every digit is terminal; in stop mode that
    // same condition freezes all steps so the chain parks at terminal.
    always_comb begin
        wrap = bus.en & ~stall & ~bus.clr & ~bus.load & (&is_term);
`ifdef COUNT_MODN_STOP_EN
        freeze = wrap;
`else
        freeze = 1'b0;
`endif
        step = '0;
        acc  = bus.en & ~stall & ~freeze;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            step[i] = acc;
            acc     = acc & is_term[i];
        end
        bus.co = wrap;
    end

    always_comb begin
        bus.count = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            bus.count[i*W +: W] = q[i];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        count_modn_digit #(
            .MODULUS (MODULUS)
        ) u_digit (
            .clk     (clk),
            .rst     (rst),
            .clr     (bus.clr),
            .load    (bus.load),
            .load_d  (bus.load_val[g*W +: W]),
            .step    (step[g]),
            .up_dn   (bus.up_dn),
            .q       (q[g]),
            .is_term (is_term[g])
        );
    end

endmodule

// File: tb/tb_count_modn_chain.sv
// Randomised and directed bench for count_modn_chain against an integer model
// of the whole chain value (supports COUNT_MODN_STOP_EN builds).
module tb_count_modn_chain;
    import count_modn_pkg::*;

    localparam int unsigned MODULUS = 10;
    localparam int unsigned DIGITS  = 2;
    localparam int unsigned W       = digit_width(MODULUS);
    localparam int unsigned TOTAL   = MODULUS ** DIGITS;
`ifdef COUNT_MODN_STOP_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk;
    logic rst;

    count_modn_chain_if #(.MODULUS(MODULUS), .DIGITS(DIGITS)) bus ();

    count_modn_chain #(
        .MODULUS (MODULUS),
        .DIGITS  (DIGITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned mval     = 0;
    bit          mdone    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DIGITS*W-1:0] pack(input int unsigned v);
        logic [DIGITS*W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*W +: W] = W'(v % MODULUS);
            v = v / MODULUS;
        end
        return r;
    endfunction

    function automatic int unsigned load_value(input logic [DIGITS*W-1:0] lv);
        int unsigned v;
        int unsigned weight;
        int unsigned d;
        v      = 0;
        weight = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = 32'(lv[i*W +: W]);
            if (d > MODULUS - 1) d = MODULUS - 1;
            v      = v + d * weight;
            weight = weight * MODULUS;
        end
        return v;
    endfunction

    // Check outputs for the current cycle, advance the model, cross one edge.
    task automatic tick(input string tag);
        bit up;
        bit wrap;
        #1;
        up   = bus.up_dn;
        wrap = bus.en && !bus.clr && !bus.load && !mdone &&
               (up ? (mval == TOTAL - 1) : (mval == 0));
        check({tag, ".count"}, 32'(bus.count), 32'(pack(mval)));
        check({tag, ".co"}, 32'(bus.co), 32'(wrap));
`ifdef COUNT_MODN_STOP_EN
        check({tag, ".done"}, 32'(bus.done), 32'(mdone));
`endif
        if (bus.clr) begin
            mval  = 0;
            mdone = 1'b0;
        end else if (bus.load) begin
            mval  = load_value(bus.load_val);
            mdone = 1'b0;
        end else if (bus.en && !mdone) begin
            if (wrap && STOP) mdone = 1'b1;
            else if (up)      mval  = (mval + 1) % TOTAL;
            else              mval  = (mval + TOTAL - 1) % TOTAL;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input bit up, input bit clr, input bit load,
                         input logic [DIGITS*W-1:0] lv);
        bus.en       = en;
        bus.up_dn    = up;
        bus.clr      = clr;
        bus.load     = load;
        bus.load_val = lv;
    endtask

    logic [DIGITS*W-1:0] lv;

    initial begin
        rst = 1'b1;
        drive(0, 1, 0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.count", 32'(bus.count), 32'(pack(0)));
        check("reset.co", 32'(bus.co), 32'(0));
        rst = 1'b0;

        drive(1, 1, 0, 0, '0);
        repeat (100) tick("up");
        check("up_wrap_model", 32'(bus.count), 32'(pack(mval)));
        drive(0, 1, 1, 0, '0);
        tick("clr_after_up");

        drive(0, 1, 0, 1, pack(35));
        tick("load35");
        drive(1, 1, 0, 0, '0);
        repeat (2) tick("to37");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.count", 32'(bus.count), 32'(0));
        check("async_rst.co", 32'(bus.co), 32'(0));
        mval  = 0;
        mdone = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1, 0, 0, '0);
        tick("post_rst");

        drive(1, 0, 0, 1, pack(0));
        tick("load00");
        drive(1, 0, 0, 0, '0);
        repeat (15) tick("down");
        drive(0, 0, 1, 0, '0);
        tick("clr_after_down");

        lv = '0;
        lv[W +: W] = W'(3);
        lv[0 +: W] = W'(12);
        drive(1, 1, 0, 1, lv);
        tick("load_clamp");
        drive(0, 1, 0, 0, '0);
        tick("clamp_hold");
        check("clamp_39", 32'(bus.count), 32'(8'h39));

        drive(0, 1, 0, 1, pack(45));
        tick("load45");
        drive(1, 1, 1, 1, pack(77));
        tick("clr_load_en");
        drive(0, 0, 0, 0, '0);
        repeat (5) tick("idle");
        check("prio_00", 32'(bus.count), 32'(8'h00));

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 9) < 7, ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
                  (DIGITS*W)'($urandom));
            tick("rand");
        end

        drive(0, 1, 0, 1, pack(98));
        tick("load98");
        drive(1, 1, 0, 0, '0);
        repeat (4) tick("stop_up");
        drive(1, 1, 1, 0, '0);
        tick("stop_clr");
        drive(1, 1, 0, 0, '0);
        repeat (2) tick("after_stop");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
